// File: rtl/wb_master_pkg.sv
// Shared types and constants for the single-transfer Wishbone classic master.
// Holds the FSM encoding, response status codes and bus widths.
package wb_master_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_DECODE  = 2'b11;

    // Inclusive unsigned window test; the borrow bit of a 33-bit subtraction
    // keeps the compare honest even when a bound sits at 0 or 2^32-1.
    function automatic logic adr_in_range(input logic [ADR_W-1:0] adr,
                                          input logic [ADR_W-1:0] lo,
                                          input logic [ADR_W-1:0] hi);
        logic [ADR_W:0] d_lo;
        logic [ADR_W:0] d_hi;
        d_lo = {1'b0, adr} - {1'b0, lo};
        d_hi = {1'b0, hi} - {1'b0, adr};
        return ~d_lo[ADR_W] & ~d_hi[ADR_W];
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating cycle counter for the BUS state; o_tc flags the last allowed cycle.
// C_TIMEOUT = 0 ties o_tc low so a transfer can wait forever.
module wb_timeout_cnt #(
    parameter int C_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W      = (C_TIMEOUT < 1) ? 1 : $clog2(C_TIMEOUT + 1);
    localparam int TC_INT = (C_TIMEOUT < 1) ? 0 : C_TIMEOUT - 1;
    localparam logic [W-1:0] TC_VAL = TC_INT[W-1:0];

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (C_TIMEOUT != 0) && (r_cnt == TC_VAL);

endmodule

// File: rtl/wb_master_seq.sv
// Single-transfer Wishbone classic master: one command in, one cyc/stb cycle,
// one response out. Valid/ready: a transfer happens on a rising edge where both are high.
module wb_master_seq
    import wb_master_pkg::*;
#(
    parameter logic [ADR_W-1:0] C_BASEADDR = 32'h0000_0000,
    parameter logic [ADR_W-1:0] C_HIGHADDR = 32'h0000_FFFF,
    parameter int               C_TIMEOUT  = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic [1:0]       rsp_status_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    output logic             stray_o,
    output logic [1:0]       dbg_state_o
);

    state_t           r_state;
    state_t           w_next;
    logic             w_hs;
    logic             w_in_range;
    logic             w_tc;
    logic             r_we;
    logic [SEL_W-1:0] r_sel;
    logic [ADR_W-1:0] r_adr;
    logic [DAT_W-1:0] r_dat;
    logic [DAT_W-1:0] r_rsp_dat;
    logic [1:0]       r_rsp_status;
    logic             r_stray;

    assign w_in_range = adr_in_range(cmd_adr_i, C_BASEADDR, C_HIGHADDR);

    wb_timeout_cnt #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .i_clr (w_hs),
        .i_en  (r_state == BUS),
        .o_tc  (w_tc)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ready is gated by reset itself so it reads 0 while reset is held.
    always_comb begin
        w_next      = r_state;
        cmd_ready_o = (r_state == IDLE) && wb_rst_i;
        w_hs        = cmd_valid_i && cmd_ready_o;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_next = w_in_range ? BUS : RESP;
                end
            end
            BUS: begin
                if (wbm_err_i || wbm_ack_i || w_tc) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_stray      <= 1'b0;
        end else begin
            r_stray <= (wbm_ack_i || wbm_err_i) && (r_state != BUS);
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_we         <= cmd_we_i;
                        r_sel        <= cmd_sel_i;
                        r_adr        <= cmd_adr_i;
                        r_dat        <= cmd_dat_i;
                        r_rsp_dat    <= '0;
                        r_rsp_status <= w_in_range ? ST_OK : ST_DECODE;
                    end
                end
                BUS: begin
                    // err outranks ack; only an OK read returns data.
                    if (wbm_err_i) begin
                        r_rsp_status <= ST_ERR;
                        r_rsp_dat    <= '0;
                    end else if (wbm_ack_i) begin
                        r_rsp_status <= ST_OK;
                        r_rsp_dat    <= r_we ? '0 : wbm_dat_i;
                    end else if (w_tc) begin
                        r_rsp_status <= ST_TIMEOUT;
                        r_rsp_dat    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm_cyc_o    = (r_state == BUS);
    assign wbm_stb_o    = (r_state == BUS);
    assign wbm_we_o     = r_we;
    assign wbm_sel_o    = r_sel;
    assign wbm_adr_o    = r_adr;
    assign wbm_dat_o    = r_dat;
    assign rsp_valid_o  = (r_state == RESP);
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;
    assign stray_o      = r_stray;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_wb_master_seq.sv
// Bench for wb_master_seq: a one-register slave model, a response scoreboard
// and one task per scenario.
module tb_wb_master_seq;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [3:0]  cmd_sel_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        stray_o;
    logic [1:0]  dbg_state_o;

    localparam logic [1:0] S_OK = 2'b00, S_ERR = 2'b01, S_TMO = 2'b10, S_DEC = 2'b11;

    // Slave model controls and storage
    logic        slv_auto  = 1'b1;
    logic        slv_err   = 1'b0;
    logic        force_ack = 1'b0;
    logic        force_err = 1'b0;
    logic [31:0] slv_reg   = 32'h0;

    logic [31:0] exp_reg = 32'h0;
    logic [33:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt = 0, cyc_noack_cnt = 0, stray_cnt = 0, cyc_stb_diff = 0;

    wb_master_seq dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_sel_i    (cmd_sel_i),
        .cmd_adr_i    (cmd_adr_i),
        .cmd_dat_i    (cmd_dat_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_status_o (rsp_status_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i),
        .stray_o      (stray_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock / reset
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Slave: combinational ack/err, byte-lane write on an acked, error-free write
    assign wbm_ack_i = (slv_auto & wbm_cyc_o & wbm_stb_o) | force_ack;
    assign wbm_err_i = (slv_err & wbm_cyc_o & wbm_stb_o) | force_err;
    assign wbm_dat_i = slv_reg;

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i && wbm_we_o) begin
            for (int i = 0; i < 4; i++) begin
                if (wbm_sel_o[i]) slv_reg[8*i +: 8] <= wbm_dat_o[8*i +: 8];
            end
        end
    end

    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o) cyc_cnt++;
        if (wbm_cyc_o && !wbm_ack_i) cyc_noack_cnt++;
        if (wbm_cyc_o !== wbm_stb_o) cyc_stb_diff++;
        if (stray_o) stray_cnt++;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Driver tasks
    task automatic send_cmd(input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
        int w;
        cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat;
        cmd_valid_i = 1'b1;
        w = 0;
        while (!cmd_ready_o && w < 60) begin
            @(negedge wb_clk_i);
            w++;
        end
        n_checks++;
        if (!cmd_ready_o) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready_o=%b after %0d cycles, required 1", cmd_ready_o, w);
        end
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic recv_rsp(input string name, output int waits);
        logic [33:0] exp;
        waits = 0;
        while (!rsp_valid_o && waits < 100) begin
            @(negedge wb_clk_i);
            waits++;
        end
        n_checks++;
        if (!rsp_valid_o) begin
            n_fail++;
            $display("FAIL %s_rsp_valid: no response within %0d cycles", name, waits);
            return;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected: got status=%b dat=%h, none expected", name, rsp_status_o, rsp_dat_o);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_status_o, rsp_dat_o} !== exp) begin
                n_fail++;
                $display("FAIL %s_rsp: got status=%b dat=%h, required status=%b dat=%h",
                         name, rsp_status_o, rsp_dat_o, exp[33:32], exp[31:0]);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        wb_rst_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_sel_i = '0; cmd_adr_i = '0; cmd_dat_i = '0;
        rsp_ready_i = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
             rsp_valid_o, rsp_dat_o, rsp_status_o, stray_o, dbg_state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b cyc=%b rsp_valid=%b state=%0d, required all 0",
                     cmd_ready_o, wbm_cyc_o, rsp_valid_o, dbg_state_o);
        end
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1 || dbg_state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b state=%0d, required ready=1 state=0", cmd_ready_o, dbg_state_o);
        end
        @(negedge wb_clk_i);
    endtask

    task automatic test_write_read();
        int w, c0, n0;
        // Full write, then read back
        c0 = cyc_cnt; n0 = cyc_noack_cnt;
        exp_reg = merge(exp_reg, 32'hEEEE_EEEE, 4'hF);
        exp_q.push_back({S_OK, 32'h0});
        send_cmd(1'b1, 4'hF, 32'h0, 32'hEEEE_EEEE);
        recv_rsp("wr_full", w);
        n_checks++;
        if (w !== 1 || cyc_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL wr_full_timing: latency=%0d cyc_cycles=%0d, required 1 and 1", w, cyc_cnt - c0);
        end
        c0 = cyc_cnt;
        exp_q.push_back({S_OK, exp_reg});
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0);
        recv_rsp("rd_full", w);
        n_checks++;
        if (cyc_cnt - c0 !== 1 || cyc_noack_cnt - n0 !== 0) begin
            n_fail++;
            $display("FAIL rd_full_cyc: cyc_cycles=%0d cyc_without_ack=%0d, required 1 and 0",
                     cyc_cnt - c0, cyc_noack_cnt - n0);
        end
        // Partial byte-lane write, read back at the inclusive high bound
        exp_reg = merge(exp_reg, 32'h1111_ABCD, 4'h3);
        exp_q.push_back({S_OK, 32'h0});
        send_cmd(1'b1, 4'h3, 32'h0000_0004, 32'h1111_ABCD);
        recv_rsp("wr_sel", w);
        exp_q.push_back({S_OK, exp_reg});
        send_cmd(1'b0, 4'hF, 32'h0000_FFFF, 32'h0);
        recv_rsp("rd_highaddr", w);
    endtask

    task automatic test_decode();
        int w, c0;
        c0 = cyc_cnt;
        exp_q.push_back({S_DEC, 32'h0});
        send_cmd(1'b0, 4'hF, 32'h0001_0000, 32'h0);
        recv_rsp("decode_rd", w);
        n_checks++;
        if (w !== 0 || cyc_cnt - c0 !== 0) begin
            n_fail++;
            $display("FAIL decode_rd_timing: latency=%0d cyc_cycles=%0d, required 0 and 0", w, cyc_cnt - c0);
        end
        exp_q.push_back({S_DEC, 32'h0});
        send_cmd(1'b1, 4'hF, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        recv_rsp("decode_wr", w);
        n_checks++;
        if (cyc_cnt - c0 !== 0) begin
            n_fail++;
            $display("FAIL decode_wr_cyc: cyc_cycles=%0d, required 0", cyc_cnt - c0);
        end
    endtask

    task automatic test_timeout();
        int w, c0;
        slv_auto = 1'b0;
        c0 = cyc_cnt;
        exp_q.push_back({S_TMO, 32'h0});
        send_cmd(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        recv_rsp("timeout", w);
        n_checks++;
        if (cyc_cnt - c0 !== 16 || w !== 16) begin
            n_fail++;
            $display("FAIL timeout_len: cyc_cycles=%0d latency=%0d, required 16 and 16", cyc_cnt - c0, w);
        end
        slv_auto = 1'b1;
        exp_reg = merge(exp_reg, 32'h5A5A_5A5A, 4'hF);
        exp_q.push_back({S_OK, 32'h0});
        send_cmd(1'b1, 4'hF, 32'h0000_0020, 32'h5A5A_5A5A);
        recv_rsp("after_timeout", w);
    endtask

    task automatic test_err_priority();
        int w;
        exp_reg = merge(exp_reg, 32'h1234_5678, 4'hF);
        exp_q.push_back({S_OK, 32'h0});
        send_cmd(1'b1, 4'hF, 32'h0, 32'h1234_5678);
        recv_rsp("err_setup", w);
        slv_err = 1'b1;
        exp_q.push_back({S_ERR, 32'h0});
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0);
        recv_rsp("err_rd", w);
        exp_q.push_back({S_ERR, 32'h0});
        send_cmd(1'b1, 4'hF, 32'h0, 32'hFFFF_0000);
        recv_rsp("err_wr", w);
        slv_err = 1'b0;
        exp_q.push_back({S_OK, exp_reg});
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0);
        recv_rsp("err_wr_nowrite", w);
    endtask

    task automatic test_backpressure_stray();
        int w, s0;
        logic [33:0] exp;
        exp = {S_OK, exp_reg};
        exp_q.push_back(exp);
        send_cmd(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        w = 0;
        while (!rsp_valid_o && w < 50) begin
            @(negedge wb_clk_i);
            w++;
        end
        s0 = stray_cnt;
        for (int i = 0; i < 10; i++) begin
            force_ack = (i == 3);
            n_checks++;
            if (rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || {rsp_status_o, rsp_dat_o} !== exp) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%b ready=%b status=%b dat=%h, required 1 0 %b %h",
                         i, rsp_valid_o, cmd_ready_o, rsp_status_o, rsp_dat_o, exp[33:32], exp[31:0]);
            end
            @(negedge wb_clk_i);
        end
        force_ack = 1'b0;
        n_checks++;
        if (stray_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL stray_resp: pulses=%0d, required 1", stray_cnt - s0);
        end
        recv_rsp("backpressure", w);
        // Stray err while idle
        s0 = stray_cnt;
        force_err = 1'b1;
        @(negedge wb_clk_i);
        force_err = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        n_checks++;
        if (stray_cnt - s0 !== 1 || dbg_state_o !== 2'd0 || rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: pulses=%0d state=%0d valid=%b, required 1 0 0",
                     stray_cnt - s0, dbg_state_o, rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic we;
        logic [3:0] sel;
        logic [31:0] dat, adr;
        for (int i = 0; i < 10; i++) begin
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(1, 15));
            dat = $urandom;
            adr = 32'($urandom_range(0, 16'hFFFF));
            if (we) begin
                exp_reg = merge(exp_reg, dat, sel);
                exp_q.push_back({S_OK, 32'h0});
            end else begin
                exp_q.push_back({S_OK, exp_reg});
            end
            send_cmd(we, sel, adr, dat);
            recv_rsp("b2b", w);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int w;
        slv_auto = 1'b0;
        send_cmd(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b0;
        #1;
        n_checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: cyc=%b stb=%b ready=%b, required 0 0 0", wbm_cyc_o, wbm_stb_o, cmd_ready_o);
        end
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        slv_auto = 1'b1;
        #1;
        n_checks++;
        if (dbg_state_o !== 2'd0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_release: state=%0d valid=%b ready=%b, required 0 0 1",
                     dbg_state_o, rsp_valid_o, cmd_ready_o);
        end
        exp_q.push_back({S_OK, exp_reg});
        @(negedge wb_clk_i);
        send_cmd(1'b0, 4'hF, 32'h0, 32'h0);
        recv_rsp("after_rst", w);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_decode();
        test_timeout();
        test_err_priority();
        test_backpressure_stray();
        test_back_to_back();
        test_reset_mid_transfer();
        n_checks++;
        if (exp_q.size() != 0 || cyc_stb_diff != 0) begin
            n_fail++;
            $display("FAIL final: pending=%0d cyc_stb_diff=%0d, required 0 and 0", exp_q.size(), cyc_stb_diff);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
